apb_initiator: RTL

- APB requester that turns single-beat read/write commands from the PLC core into APB transfers.
- Drives the peripheral slave decoders (timer, counter and I/O register banks) on the shared APB bus.
- Handles one outstanding transfer at a time, supports slave wait states, and returns read data and error status on a valid/ready response channel.

---
 rtl/apb_pkg.sv | 23 ++
 rtl/apb_initiator.sv | 126 ++++++++++++
 2 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: definitions shared by the APB initiator and its users.
//   - apb_state_e : initiator FSM state encoding
//   - apb_rsp_t   : response payload (error flag + read data)
//   - APB_DATA_W  : APB data bus width
//   - APB_ADDR_W_DEFAULT : default APB address width
package apb_pkg;

    localparam int APB_DATA_W         = 32;
    localparam int APB_ADDR_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    typedef struct packed {
        logic                  err;
        logic [APB_DATA_W-1:0] rdata;
    } apb_rsp_t;

endpackage

// File: rtl/apb_initiator.sv
// apb_initiator: turns single-beat read/write commands into APB transfers.
// One transfer in flight at a time; slave wait states are honoured and the
// result is returned on a valid/ready response channel.
//
// Optional feature (macro APB_TIMEOUT_EN): an ACCESS-phase watchdog aborts a
// transfer whose slave stalls for too long and reports it as an error.
//
// Ports:
//   pclk, presetn            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready      command handshake (ready only while IDLE)
//   cmd_write/addr/wdata     command payload
//   rsp_valid/rsp_ready      response handshake
//   rsp_rdata/rsp_err        response payload (rdata = 0 for writes)
//   paddr/psel/penable/pwrite/pwdata   APB requester outputs (registered)
//   prdata/pready/pslverr    APB completer inputs
module apb_initiator
    import apb_pkg::*;
#(
    parameter int APB_ADDR_W     = APB_ADDR_W_DEFAULT,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_W      = 8
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [APB_ADDR_W-1:0] cmd_addr,
    input  logic [APB_DATA_W-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [APB_DATA_W-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [APB_ADDR_W-1:0] paddr,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [APB_DATA_W-1:0] pwdata,
    input  logic [APB_DATA_W-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    // The watchdog counter must be able to reach its limit.
    if (TIMEOUT_CYCLES >= (2 ** TIMEOUT_W)) begin : g_bad_timeout
        $error("TIMEOUT_W too narrow for TIMEOUT_CYCLES");
    end

    apb_state_e state;
    apb_rsp_t   rsp_q;

`ifdef APB_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] to_cnt;
`endif

    assign cmd_ready = (state == IDLE);
    assign rsp_rdata = rsp_q.rdata;
    assign rsp_err   = rsp_q.err;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state     <= IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_q     <= '0;
`ifdef APB_TIMEOUT_EN
            to_cnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        paddr  <= cmd_addr;
                        pwrite <= cmd_write;
                        pwdata <= cmd_wdata;
                        psel   <= 1'b1;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
`ifdef APB_TIMEOUT_EN
                    to_cnt  <= '0;
`endif
                    state   <= ACCESS;
                end
                ACCESS: begin
                    // Completion takes priority over the watchdog limit.
                    if (pready) begin
                        rsp_q.rdata <= pwrite ? '0 : prdata;
                        rsp_q.err   <= pslverr;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (to_cnt == TIMEOUT_W'(TIMEOUT_CYCLES)) begin
                        rsp_q.rdata <= '0;
                        rsp_q.err   <= 1'b1;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    // rsp_q is left alone so the last result stays readable.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
